// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// Index fields are sized for up to 2**ARB_IDX_MAX_W inputs; the top slices to IDX_W.
package stream_arb_pkg;

  localparam int ARB_IDX_MAX_W = 8;

  typedef logic [ARB_IDX_MAX_W-1:0] arb_idx_t;

  typedef struct packed {
    arb_idx_t rr_ptr;
    logic     lock;
    arb_idx_t lock_idx;
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic arb_idx_t rr_next(input arb_idx_t idx, input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + arb_idx_t'(1);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority pick: rotate requests by the start pointer, take the
// lowest set bit, and map it back to an absolute input index.
module rr_priority_select
  import stream_arb_pkg::*;
#(
  parameter int N_INP = 3
) (
  input  logic [N_INP-1:0] req,
  input  arb_idx_t         start,
  output logic             gnt_valid,
  output arb_idx_t         gnt_idx
);

  logic [N_INP-1:0] req_rot;
  int               base;

  always_comb begin
    base    = int'(start) % N_INP;
    req_rot = '0;
    for (int k = 0; k < N_INP; k++) begin
      for (int j = 0; j < N_INP; j++) begin
        if (j == (base + k) % N_INP) req_rot[k] = req[j];
      end
    end
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    // Descending scan so the lowest rotated position is the one that sticks.
    for (int k = N_INP - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        gnt_valid = 1'b1;
        gnt_idx   = arb_idx_t'((base + k) % N_INP);
      end
    end
  end

endmodule

// File: rtl/stream_arbiter_rr_n_inp3.sv
// Round-robin valid/ready stream arbiter with grant lock on stall and source index output.
// Define STREAM_ARB_OUT_REG_EN to add a full-throughput output register (1 cycle latency).
module stream_arbiter_rr_n_inp3
  import stream_arb_pkg::*;
#(
  parameter  int N_INP      = 3,
  parameter  int DATA_WIDTH = 8,
  localparam int IDX_W      = idx_width(N_INP)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_INP-1:0]            inp_valid_i,
  output logic [N_INP-1:0]            inp_ready_o,
  input  logic [N_INP*DATA_WIDTH-1:0] inp_data_i,
  output logic                        oup_valid_o,
  input  logic                        oup_ready_i,
  output logic [DATA_WIDTH-1:0]       oup_data_o,
  output logic [IDX_W-1:0]            oup_idx_o
);

  arb_state_t              state_q, state_d;
  logic                    sel_valid;
  arb_idx_t                sel_idx;
  logic                    gnt_any;
  arb_idx_t                gnt_idx;
  logic                    arb_valid;
  logic [DATA_WIDTH-1:0]   arb_data;
  logic                    ds_ready;
  logic                    arb_hs;

  rr_priority_select #(
    .N_INP(N_INP)
  ) u_rr_sel (
    .req       (inp_valid_i),
    .start     (state_q.rr_ptr),
    .gnt_valid (sel_valid),
    .gnt_idx   (sel_idx)
  );

  // A locked grant holds regardless of other requests until it is accepted.
  always_comb begin
    gnt_any = state_q.lock | sel_valid;
    gnt_idx = state_q.lock ? state_q.lock_idx : sel_idx;
  end

  always_comb begin
    arb_valid = 1'b0;
    arb_data  = '0;
    for (int i = 0; i < N_INP; i++) begin
      if (gnt_any && (gnt_idx == arb_idx_t'(i))) begin
        arb_valid = inp_valid_i[i];
        arb_data  = inp_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    inp_ready_o = '0;
    for (int i = 0; i < N_INP; i++) begin
      inp_ready_o[i] = rst_ni & ds_ready & gnt_any & (gnt_idx == arb_idx_t'(i));
    end
  end

  assign arb_hs = arb_valid & ds_ready;

  always_comb begin
    state_d = state_q;
    if (arb_hs) begin
      state_d.rr_ptr = rr_next(gnt_idx, N_INP);
      state_d.lock   = 1'b0;
    end else if (arb_valid) begin
      state_d.lock     = 1'b1;
      state_d.lock_idx = gnt_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef STREAM_ARB_OUT_REG_EN
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [IDX_W-1:0]      idx_p1;

  assign ds_ready = ~vld_p1 | oup_ready_i;

  // ---- stage p1: output register ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      idx_p1  <= '0;
    end else if (arb_hs) begin
      vld_p1  <= 1'b1;
      data_p1 <= arb_data;
      idx_p1  <= gnt_idx[IDX_W-1:0];
    end else if (oup_ready_i) begin
      vld_p1  <= 1'b0;
    end
  end

  assign oup_valid_o = vld_p1;
  assign oup_data_o  = data_p1;
  assign oup_idx_o   = idx_p1;
`else
  assign ds_ready    = oup_ready_i;
  assign oup_valid_o = rst_ni & arb_valid;
  assign oup_data_o  = arb_data;
  assign oup_idx_o   = gnt_idx[IDX_W-1:0];
`endif

  // A locked source must keep valid asserted until its beat is accepted.
  lock_hold_valid : assert property (
    @(posedge clk_i) disable iff (!rst_ni) state_q.lock |-> arb_valid
  ) else $error("stream_arbiter: locked input dropped valid before handshake");

endmodule

// File: tb/tb_stream_arbiter_rr_n_inp3.sv
// Bench for stream_arbiter_rr_n_inp3: directed steps plus random traffic against a
// round-robin reference model, per-source scoreboard and starvation bound.
module tb_stream_arbiter_rr_n_inp3;

  localparam int N  = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  inp_valid;
  logic [N-1:0]  inp_ready;
  logic [N*DW-1:0] inp_data;
  logic          oup_valid;
  logic          oup_ready;
  logic [DW-1:0] oup_data;
  logic [1:0]    oup_idx;

  always #5 clk = ~clk;

  stream_arbiter_rr_n_inp3 #(.N_INP(N), .DATA_WIDTH(DW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .inp_valid_i (inp_valid),
    .inp_ready_o (inp_ready),
    .inp_data_i  (inp_data),
    .oup_valid_o (oup_valid),
    .oup_ready_i (oup_ready),
    .oup_data_o  (oup_data),
    .oup_idx_o   (oup_idx)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state
  int       m_ptr;
  bit       m_lk;
  int       m_lk_idx;
  bit       slot_v;
  int       slot_i;
  logic [7:0] slot_d;

  logic [7:0] sb [N][$];
  int         waits [N];
  int         max_wait;

  logic [1:0] last_idx;
  logic       last_valid;
  logic [2:0] last_ready;
  logic [7:0] last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst_ni   = 1'b0;
    m_ptr    = 0;
    m_lk     = 1'b0;
    m_lk_idx = 0;
    slot_v   = 1'b0;
    @(negedge clk);
    chk("rst_oup_valid", oup_valid, 0);
    chk("rst_inp_ready", inp_ready, 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic cycle(input logic [2:0] want, input logic rdy);
    int         g;
    bit         gv, av, ds, ahs;
    logic [7:0] ad;
    logic [7:0] exp_d;
    logic [2:0] er;
    logic [2:0] acc;
    int         hs_src;
    for (int i = 0; i < N; i++) begin
      if (!inp_valid[i] && want[i]) begin
        inp_valid[i]        = 1'b1;
        inp_data[i*DW +: DW] = 8'($urandom);
      end
    end
    oup_ready = rdy;
    @(negedge clk);
`ifdef STREAM_ARB_OUT_REG_EN
    ds = !slot_v || rdy;
`else
    ds = rdy;
`endif
    gv = 1'b0;
    g  = 0;
    if (m_lk) begin
      gv = 1'b1;
      g  = m_lk_idx;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!gv && inp_valid[(m_ptr + k) % N]) begin
          gv = 1'b1;
          g  = (m_ptr + k) % N;
        end
      end
    end
    av = gv && inp_valid[g];
    ad = inp_data[g*DW +: DW];
    er = (gv && ds) ? 3'(1 << g) : 3'b000;
    chk("inp_ready", inp_ready, er);
`ifdef STREAM_ARB_OUT_REG_EN
    chk("oup_valid", oup_valid, slot_v);
    if (slot_v) begin
      chk("oup_idx", oup_idx, slot_i);
      chk("oup_data", oup_data, slot_d);
    end
`else
    chk("oup_valid", oup_valid, av);
    if (av) begin
      chk("oup_idx", oup_idx, g);
      chk("oup_data", oup_data, ad);
    end
`endif
    acc    = '0;
    hs_src = -1;
    for (int i = 0; i < N; i++) begin
      if (inp_valid[i] && inp_ready[i]) begin
        acc[i] = 1'b1;
        sb[i].push_back(inp_data[i*DW +: DW]);
        hs_src = i;
      end
    end
    if (hs_src >= 0) begin
      for (int i = 0; i < N; i++) begin
        if (i == hs_src) waits[i] = 0;
        else if (inp_valid[i]) begin
          waits[i]++;
          if (waits[i] > max_wait) max_wait = waits[i];
        end
      end
    end
    if (oup_valid && rdy) begin
      if (oup_idx >= 2'(N) || sb[oup_idx].size() == 0) begin
        chk("sb_unexpected_beat", 1, 0);
      end else begin
        exp_d = sb[oup_idx].pop_front();
        chk("sb_data", oup_data, exp_d);
      end
    end
    last_idx   = oup_idx;
    last_valid = oup_valid;
    last_ready = inp_ready;
    last_data  = oup_data;
    @(posedge clk);
    ahs = av && ds;
    if (ahs) begin
      m_ptr = (g + 1) % N;
      m_lk  = 1'b0;
    end else if (av) begin
      m_lk     = 1'b1;
      m_lk_idx = g;
    end
`ifdef STREAM_ARB_OUT_REG_EN
    if (ahs) begin
      slot_v = 1'b1;
      slot_i = g;
      slot_d = ad;
    end else if (rdy) begin
      slot_v = 1'b0;
    end
`endif
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) inp_valid[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] held;
    max_wait  = 0;
    for (int i = 0; i < N; i++) waits[i] = 0;
    rst_ni    = 1'b0;
    oup_ready = 1'b1;
    inp_valid = 3'b111;
    for (int i = 0; i < N; i++) inp_data[i*DW +: DW] = 8'($urandom);
    apply_reset();

`ifndef STREAM_ARB_OUT_REG_EN
    // all valid, ready high: strict rotation
    for (int k = 0; k < 6; k++) begin
      cycle(3'b111, 1'b1);
      chk("t1_idx", last_idx, k % 3);
    end
    // stall locks grant 0 while others arrive
    cycle(3'b011, 1'b0);
    held = last_data;
    chk("t2_idx_lock", last_idx, 0);
    for (int k = 0; k < 2; k++) begin
      cycle(3'b011, 1'b0);
      chk("t2_idx_lock", last_idx, 0);
      chk("t2_data_stable", last_data, held);
    end
    cycle(3'b111, 1'b0);
    chk("t2_idx_lock_all", last_idx, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(3'b111, 1'b1);
      chk("t2_accept_order", last_idx, k);
    end
    cycle(3'b000, 1'b1);
    cycle(3'b000, 1'b1);
    // wrap from input 2, then sparse grant with pointer at 0
    cycle(3'b100, 1'b1);
    chk("t3_wrap_idx", last_idx, 2);
    cycle(3'b100, 1'b1);
    chk("t4_sparse_idx", last_idx, 2);
    chk("t4_sparse_ready", last_ready, 3'b100);
    chk("t4_sparse_valid", last_valid, 1);
    cycle(3'b101, 1'b1);
    chk("t3_idx0", last_idx, 0);
    cycle(3'b000, 1'b1);
    chk("t3_idx2", last_idx, 2);
    // lock on input 1, then reset mid-operation
    cycle(3'b001, 1'b1);
    cycle(3'b010, 1'b0);
    chk("t5_lock_idx", last_idx, 1);
    cycle(3'b011, 1'b0);
    chk("t5_lock_hold", last_idx, 1);
    apply_reset();
    cycle(3'b011, 1'b1);
    chk("t5_unlocked_idx", last_idx, 0);
    cycle(3'b000, 1'b1);
    chk("t5_next_idx", last_idx, 1);
`else
    cycle(3'b111, 1'b1);
    chk("t6_first_latency", last_valid, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(3'b111, 1'b1);
      chk("t6_valid", last_valid, 1);
      chk("t6_idx", last_idx, k);
    end
`endif

    for (int k = 0; k < 400; k++) begin
      cycle(3'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int k = 0; k < 8; k++) cycle(3'b000, 1'b1);
    for (int i = 0; i < N; i++) chk("sb_drained", sb[i].size(), 0);
    chk("no_starvation", (max_wait <= N - 1), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
